// File: rtl/dexie_pkg.sv
// Shared defaults and the record layout for the DExIE control-flow queue.
// DEXIE_CF_TIMESTAMP_EN adds a cycle-count timestamp field to each record.
package dexie_pkg;

   localparam int CF_XLEN        = 32;
   localparam int CF_QUEUE_DEPTH = 8;
   localparam int CF_SEQ_W       = 8;
   localparam int CF_DROP_W      = 16;

   // Record layout at the default widths; the queue builds the same shape
   // from its own XLEN/SEQ_W parameters.
   typedef struct packed {
      logic [CF_XLEN-1:0]  pc;
      logic [CF_XLEN-1:0]  instr;
      logic [CF_XLEN-1:0]  next_pc;
      logic [CF_SEQ_W-1:0] seq;
`ifdef DEXIE_CF_TIMESTAMP_EN
      logic [CF_XLEN-1:0]  timestamp;
`endif
   } cf_record_t;

endpackage

// File: rtl/dexie_cf_fifo_ram.sv
// DEPTH x W record storage with one write port, one asynchronous read port
// and the read/write pointers that walk it.
module dexie_cf_fifo_ram #(
   parameter  int DEPTH = 8,
   parameter  int W     = 8,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage is left unreset; only occupancy decides what is meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dexie_cf_queue.sv
// Control-flow record queue feeding the DExIE monitor: filtering, sequencing,
// stall request and drop accounting. DEXIE_CF_TIMESTAMP_EN adds out_timestamp.
module dexie_cf_queue
   import dexie_pkg::*;
#(
   parameter  int XLEN            = CF_XLEN,
   parameter  int DEPTH           = CF_QUEUE_DEPTH,
   parameter  int STALL_THRESHOLD = DEPTH - 2,
   parameter  int SEQ_W           = CF_SEQ_W,
   parameter  int DROP_W          = CF_DROP_W,
   localparam int CW              = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              filter_seq,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_next_pc,
   output logic              pipe_stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_next_pc,
   output logic [SEQ_W-1:0]  out_seq,
`ifdef DEXIE_CF_TIMESTAMP_EN
   output logic [XLEN-1:0]   out_timestamp,
`endif
   output logic [CW-1:0]     count,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [XLEN-1:0]  next_pc;
      logic [SEQ_W-1:0] seq;
`ifdef DEXIE_CF_TIMESTAMP_EN
      logic [XLEN-1:0]  timestamp;
`endif
   } rec_t;

   logic             is_seq;
   logic             in_q;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;
   logic [SEQ_W-1:0] seq_q;
   rec_t             wrec;
   rec_t             head;

   assign is_seq = (in_next_pc == in_pc + XLEN'(4));
   assign in_q   = in_valid & ~(filter_seq & is_seq);
   assign full   = (count == CW'(DEPTH));
   assign pop    = out_valid & out_ready;
   // A full queue still accepts when the head leaves in the same cycle.
   assign push   = in_q & (~full | pop);
   assign drop   = in_q & ~push;

   assign out_valid  = (count != '0);
   assign pipe_stall = (count >= CW'(STALL_THRESHOLD));

`ifdef DEXIE_CF_TIMESTAMP_EN
   logic [XLEN-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + XLEN'(1);
   end

   assign out_timestamp = head.timestamp;
`endif

   always_comb begin
      wrec         = '0;
      wrec.pc      = in_pc;
      wrec.instr   = in_instr;
      wrec.next_pc = in_next_pc;
      wrec.seq     = seq_q;
`ifdef DEXIE_CF_TIMESTAMP_EN
      wrec.timestamp = ts_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         seq_q      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (push) seq_q <= seq_q + SEQ_W'(1);
         // Drops leave seq untouched; the monitor sees gaps only via drop_count.
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

   dexie_cf_fifo_ram #(
      .DEPTH (DEPTH),
      .W     ($bits(rec_t))
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wrec),
      .rdata (head)
   );

   assign out_pc      = head.pc;
   assign out_instr   = head.instr;
   assign out_next_pc = head.next_pc;
   assign out_seq     = head.seq;

endmodule

// File: tb/tb_dexie_cf_queue.sv
// Randomised and directed bench for dexie_cf_queue with a queue-based
// reference model and a scoreboard checked by an independent monitor.
module tb_dexie_cf_queue;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 8;
   localparam int THR    = 6;
   localparam int SEQ_W  = 8;
   localparam int DROP_W = 16;
   localparam int CW     = 4;

   bit                clk;
   logic              rst;
   logic              filter_seq;
   logic              in_valid;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_instr;
   logic [XLEN-1:0]   in_next_pc;
   logic              pipe_stall;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_instr;
   logic [XLEN-1:0]   out_next_pc;
   logic [SEQ_W-1:0]  out_seq;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;
`ifdef DEXIE_CF_TIMESTAMP_EN
   logic [XLEN-1:0]   out_timestamp;
`endif

   always #5 clk = ~clk;

   dexie_cf_queue #(
      .XLEN            (XLEN),
      .DEPTH           (DEPTH),
      .STALL_THRESHOLD (THR),
      .SEQ_W           (SEQ_W),
      .DROP_W          (DROP_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .filter_seq  (filter_seq),
      .in_valid    (in_valid),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .in_next_pc  (in_next_pc),
      .pipe_stall  (pipe_stall),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_next_pc (out_next_pc),
      .out_seq     (out_seq),
`ifdef DEXIE_CF_TIMESTAMP_EN
      .out_timestamp (out_timestamp),
`endif
      .count       (count),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] npc;
      logic [7:0]  seq;
      logic [31:0] ts;
   } rec_t;

   // Reference model: accepted records in order, plus counters.
   rec_t        m_q[$];
   rec_t        sb[$];
   logic [7:0]  m_seq;
   logic        m_ovf;
   logic [15:0] m_drops;
   logic [31:0] m_ts;
   logic [7:0]  last_seq;
   int          checks;
   int          errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      rec_t r;
      bit   q_in;
      bit   do_pop;
      bit   do_push;
      if (rst) begin
         m_q.delete();
         sb.delete();
         m_seq   = 0;
         m_ovf   = 0;
         m_drops = 0;
         m_ts    = 0;
         return;
      end
      q_in    = in_valid && !(filter_seq && (in_next_pc == in_pc + 32'd4));
      do_pop  = (m_q.size() != 0) && out_ready;
      do_push = q_in && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         r.pc = in_pc; r.instr = in_instr; r.npc = in_next_pc; r.seq = m_seq; r.ts = m_ts;
         m_q.push_back(r);
         sb.push_back(r);
         m_seq = m_seq + 8'd1;
      end else if (q_in) begin
         m_ovf = 1;
         if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end
      m_ts = m_ts + 32'd1;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] npc, input logic rdy);
      in_valid   = v;
      in_pc      = pc;
      in_instr   = instr;
      in_next_pc = npc;
      out_ready  = rdy;
   endtask

   task automatic do_reset();
      apply(0, 0, 0, 0, 0);
      rst = 1;
      step();
      rst = 0;
   endtask

   // Monitor: compares DUT state with the model and retires scoreboard entries.
   initial begin
      rec_t r;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
         chk("count", 64'(count), 64'(m_q.size()));
         chk("pipe_stall", 64'(pipe_stall), 64'(m_q.size() >= THR));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("drop_count", 64'(drop_count), 64'(m_drops));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: actual out_pc %0h, expected no record", out_pc);
            end else begin
               r = sb.pop_front();
               chk("rec_pc", 64'(out_pc), 64'(r.pc));
               chk("rec_instr", 64'(out_instr), 64'(r.instr));
               chk("rec_next_pc", 64'(out_next_pc), 64'(r.npc));
               chk("rec_seq", 64'(out_seq), 64'(r.seq));
`ifdef DEXIE_CF_TIMESTAMP_EN
               chk("rec_ts", 64'(out_timestamp), 64'(r.ts));
`endif
               last_seq = out_seq;
            end
         end
      end
   end

   initial begin
      logic        rdy;
      logic        v;
      logic        ok;
      logic [31:0] pc;
      logic [31:0] npc;
      int          pushed;
      int          cyc;

      checks = 0;
      errors = 0;
      last_seq = 0;
      filter_seq = 0;
      apply(0, 0, 0, 0, 0);
      rst = 1;
      step();
      step();
      rst = 0;

      // Single record, immediate drain.
      apply(1, 32'h100, 32'h0000_006F, 32'h200, 1);
      step();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_pc", 64'(out_pc), 64'h100);
      chk("t1_npc", 64'(out_next_pc), 64'h200);
      chk("t1_seq", 64'(out_seq), 64'd0);
      apply(0, 0, 0, 0, 1);
      step();
      chk("t1_count", 64'(count), 64'd0);

      // Sequential filtering.
      do_reset();
      filter_seq = 1;
      apply(1, 32'h104, 32'h13, 32'h108, 0);
      step();
      apply(1, 32'h108, 32'h13, 32'h300, 0);
      step();
      apply(0, 0, 0, 0, 0);
      chk("t2_count", 64'(count), 64'd1);
      chk("t2_pc", 64'(out_pc), 64'h108);
      chk("t2_seq", 64'(out_seq), 64'd0);
      chk("t2_drops", 64'(drop_count), 64'd0);
      filter_seq = 0;
      apply(0, 0, 0, 0, 1);
      step();

      // Fill to the stall threshold, to full, then overflow.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         apply(1, 32'h1000 + 32'(i) * 32'h10, 32'hA000 + 32'(i), 32'h2000 + 32'(i) * 32'h10, 0);
         step();
         if (i == 4) chk("t3_stall_lo", 64'(pipe_stall), 64'd0);
         if (i == 5) chk("t3_stall_hi", 64'(pipe_stall), 64'd1);
         if (i == 7) chk("t3_full", 64'(count), 64'd8);
      end
      chk("t3_ovf", 64'(overflow), 64'd1);
      chk("t3_drops", 64'(drop_count), 64'd1);
      chk("t3_count", 64'(count), 64'd8);

      // Full with simultaneous pop.
      apply(1, 32'h5000, 32'hBEEF, 32'h6000, 1);
      step();
      chk("t4_count", 64'(count), 64'd8);
      chk("t4_drops", 64'(drop_count), 64'd1);
      apply(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step();
      chk("t4_drained", 64'(count), 64'd0);

      // Reset in the middle of a stream, asserted together with push and pop.
      for (int i = 0; i < 5; i++) begin
         apply(1, 32'h7000 + 32'(i) * 32'h8, 32'h1, 32'h9000, 0);
         step();
      end
      chk("t5_count5", 64'(count), 64'd5);
      apply(1, 32'h7777, 32'h1, 32'h8888, 1);
      rst = 1;
      step();
      rst = 0;
      apply(0, 0, 0, 0, 0);
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_stall", 64'(pipe_stall), 64'd0);
      chk("t5_ovf", 64'(overflow), 64'd0);
      apply(1, 32'h4000, 32'h2, 32'h4100, 0);
      step();
      chk("t5_seq", 64'(out_seq), 64'd0);
      apply(0, 0, 0, 0, 1);
      step();

      // 300 records with random back-pressure and no drops: seq wraps.
      do_reset();
      pushed = 0;
      cyc = 0;
      while (pushed < 300 && cyc < 5000) begin
         rdy = 1'($urandom_range(0, 1));
         ok  = (m_q.size() < DEPTH) || ((m_q.size() != 0) && rdy);
         v   = ok && ($urandom_range(0, 3) != 0);
         apply(v, $urandom, $urandom, $urandom, rdy);
         if (v) pushed++;
         step();
         cyc++;
      end
      chk("t6_pushed", 64'(pushed), 64'd300);
      apply(0, 0, 0, 0, 1);
      cyc = 0;
      while (m_q.size() != 0 && cyc < 20) begin
         step();
         cyc++;
      end
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_last_seq", 64'(last_seq), 64'd43);
      chk("t6_drops", 64'(drop_count), 64'd0);

      // Free-running mix: filtering, PC wrap at the top of memory, drops, resets.
      for (int c = 0; c < 600; c++) begin
         pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         npc = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : $urandom;
         filter_seq = 1'($urandom_range(0, 1));
         apply(1'($urandom_range(0, 1)), pc, $urandom, npc, ($urandom_range(0, 3) == 0));
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 0;
      filter_seq = 0;
      apply(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step();
      chk("t7_count", 64'(count), 64'd0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
